sha256_nonce_scheduler: RTL and testbench

Sequences one sha256_transform instance to run a Bitcoin double-SHA-256 nonce scan. Accepts a job of midstate, header tail, nonce range and target, then drives the transform's feedback/cnt/state/input controls for two passes per nonce. Checks each final hash against the target and reports hits, then advances the nonce until the range is exhausted or the job is aborted. Sits between the work-distribution interface and the hashing core; exactly one hash is in flight at a time.

---
 rtl/sha256_nonce_scheduler.sv | 216 +++++++++++++++++++++
 tb/tb_sha256_nonce_scheduler.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_nonce_scheduler.sv
// Double-SHA-256 nonce scan sequencer for one attached sha256_transform.
// Runs two transform passes per nonce, compares hash2 to the target and walks the nonce range.
module sha256_nonce_scheduler #(
  parameter int LOOP       = 4,
  parameter int RESULT_LAT = 17
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         job_valid,
  output logic         job_ready,
  input  logic [255:0] job_midstate,
  input  logic [95:0]  job_tail,
  input  logic [31:0]  job_nonce_start,
  input  logic [31:0]  job_nonce_end,
  input  logic [255:0] job_target,
  input  logic         abort,
  output logic         xf_feedback,
  output logic [5:0]   xf_cnt,
  output logic [255:0] xf_state,
  output logic [511:0] xf_input,
  input  logic [255:0] xf_hash,
  output logic         busy,
  output logic         found,
  output logic [31:0]  found_nonce,
  output logic [255:0] found_hash,
  output logic         done,
  output logic [31:0]  cur_nonce
);

  typedef enum logic [2:0] {
    IDLE, P1_LOAD, P1_ITER, P1_WAIT, P2_LOAD, P2_ITER, P2_WAIT, CHECK
  } state_e;

  localparam int CMAX = (LOOP > RESULT_LAT) ? LOOP : RESULT_LAT;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] ITER_LAST = CW'(LOOP - 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(RESULT_LAT - 1);
  localparam logic [255:0] SHA_IV = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};

  state_e         state_q, state_d;
  logic [CW-1:0]  cyc_q, cyc_d;
  logic [255:0]   midstate_q, midstate_d;
  logic [95:0]    tail_q, tail_d;
  logic [31:0]    end_q, end_d;
  logic [255:0]   target_q, target_d;
  logic [31:0]    cur_nonce_q, cur_nonce_d;
  logic [255:0]   hash1_q, hash1_d;
  logic           busy_q, busy_d;
  logic           found_q, found_d;
  logic [31:0]    found_nonce_q, found_nonce_d;
  logic [255:0]   found_hash_q, found_hash_d;
  logic           done_q, done_d;
  logic           last_nonce;

  assign last_nonce = (cur_nonce_q == end_q);

  always_comb begin
    state_d       = state_q;
    cyc_d         = cyc_q;
    midstate_d    = midstate_q;
    tail_d        = tail_q;
    end_d         = end_q;
    target_d      = target_q;
    cur_nonce_d   = cur_nonce_q;
    hash1_d       = hash1_q;
    busy_d        = busy_q;
    found_d       = 1'b0;
    found_nonce_d = found_nonce_q;
    found_hash_d  = found_hash_q;
    done_d        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (job_valid) begin
          state_d     = P1_LOAD;
          cyc_d       = '0;
          midstate_d  = job_midstate;
          tail_d      = job_tail;
          end_d       = job_nonce_end;
          target_d    = job_target;
          cur_nonce_d = job_nonce_start;
          busy_d      = 1'b1;
        end
      end
      P1_LOAD, P2_LOAD: begin
        if (LOOP == 1) begin
          state_d = (state_q == P1_LOAD) ? P1_WAIT : P2_WAIT;
          cyc_d   = '0;
        end else begin
          state_d = (state_q == P1_LOAD) ? P1_ITER : P2_ITER;
          cyc_d   = CW'(1);
        end
      end
      P1_ITER, P2_ITER: begin
        if (cyc_q == ITER_LAST) begin
          state_d = (state_q == P1_ITER) ? P1_WAIT : P2_WAIT;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      P1_WAIT: begin
        if (cyc_q == WAIT_LAST) begin
          hash1_d = xf_hash;
          state_d = P2_LOAD;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      P2_WAIT: begin
        // Hit and done are registered here so they pulse during CHECK.
        if (cyc_q == WAIT_LAST) begin
          state_d = CHECK;
          cyc_d   = '0;
          if (xf_hash <= target_q) begin
            found_d       = 1'b1;
            found_nonce_d = cur_nonce_q;
            found_hash_d  = xf_hash;
          end
          done_d = last_nonce;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      CHECK: begin
        if (last_nonce) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          state_d     = P1_LOAD;
          cur_nonce_d = cur_nonce_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Abort wins over everything; a CHECK on the last nonce already pulsed done.
    if (abort && state_q != IDLE) begin
      state_d       = IDLE;
      cyc_d         = '0;
      busy_d        = 1'b0;
      found_d       = 1'b0;
      found_nonce_d = found_nonce_q;
      found_hash_d  = found_hash_q;
      cur_nonce_d   = cur_nonce_q;
      done_d        = !(state_q == CHECK && last_nonce);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cyc_q         <= '0;
      midstate_q    <= '0;
      tail_q        <= '0;
      end_q         <= '0;
      target_q      <= '0;
      cur_nonce_q   <= '0;
      hash1_q       <= '0;
      busy_q        <= 1'b0;
      found_q       <= 1'b0;
      found_nonce_q <= '0;
      found_hash_q  <= '0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cyc_q         <= cyc_d;
      midstate_q    <= midstate_d;
      tail_q        <= tail_d;
      end_q         <= end_d;
      target_q      <= target_d;
      cur_nonce_q   <= cur_nonce_d;
      hash1_q       <= hash1_d;
      busy_q        <= busy_d;
      found_q       <= found_d;
      found_nonce_q <= found_nonce_d;
      found_hash_q  <= found_hash_d;
      done_q        <= done_d;
    end
  end

  // Transform controls are decoded from state so they drop to 0 with reset.
  always_comb begin
    xf_feedback = 1'b0;
    xf_cnt      = 6'd0;
    xf_state    = '0;
    xf_input    = '0;
    unique case (state_q)
      P1_LOAD, P1_ITER, P1_WAIT: begin
        xf_state = midstate_q;
        xf_input = {32'h00000280, 320'd0, 32'h80000000, cur_nonce_q, tail_q};
      end
      P2_LOAD, P2_ITER, P2_WAIT: begin
        xf_state = SHA_IV;
        xf_input = {32'h00000100, 192'd0, 32'h80000000, hash1_q};
      end
      default: ;
    endcase
    if (state_q == P1_ITER || state_q == P2_ITER) begin
      xf_feedback = 1'b1;
      xf_cnt      = 6'(cyc_q);
    end else if (state_q == P1_WAIT || state_q == P2_WAIT) begin
      xf_cnt = 6'(LOOP - 1);
    end
  end

  assign job_ready   = (state_q == IDLE) && !rst;
  assign busy        = busy_q;
  assign found       = found_q;
  assign found_nonce = found_nonce_q;
  assign found_hash  = found_hash_q;
  assign done        = done_q;
  assign cur_nonce   = cur_nonce_q;

endmodule

// File: tb/tb_sha256_nonce_scheduler.sv
// Bench for sha256_nonce_scheduler: behavioural SHA-256 transform plus a per-nonce
// double-hash reference model driving cycle-by-cycle expectations.
module tb_sha256_nonce_scheduler;
  localparam int LOOP = 4;
  localparam int RLAT = 17;
  localparam int PER  = 2 * (LOOP + RLAT) + 1;

  logic         clk, rst;
  logic         job_valid, job_ready, abort;
  logic [255:0] job_midstate, job_target;
  logic [95:0]  job_tail;
  logic [31:0]  job_nonce_start, job_nonce_end;
  logic         xf_feedback;
  logic [5:0]   xf_cnt;
  logic [255:0] xf_state, xf_hash;
  logic [511:0] xf_input;
  logic         busy, found, done;
  logic [31:0]  found_nonce, cur_nonce;
  logic [255:0] found_hash;

  int errs = 0;
  int checks = 0;

  sha256_nonce_scheduler #(.LOOP(LOOP), .RESULT_LAT(RLAT)) dut (
    .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready),
    .job_midstate(job_midstate), .job_tail(job_tail),
    .job_nonce_start(job_nonce_start), .job_nonce_end(job_nonce_end),
    .job_target(job_target), .abort(abort),
    .xf_feedback(xf_feedback), .xf_cnt(xf_cnt), .xf_state(xf_state),
    .xf_input(xf_input), .xf_hash(xf_hash), .busy(busy), .found(found),
    .found_nonce(found_nonce), .found_hash(found_hash), .done(done),
    .cur_nonce(cur_nonce));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
  localparam logic [31:0] IVW [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] iv256();
    logic [255:0] r;
    for (int j = 0; j < 8; j++) r[32*j +: 32] = IVW[j];
    return r;
  endfunction

  // Word j of state/block lives at [32j+31:32j].
  function automatic logic [255:0] compress(input logic [255:0] st, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] h [8];
    logic [31:0] a, b, c, d, e, f, g, hh, t1, t2;
    logic [255:0] r;
    for (int j = 0; j < 16; j++) w[j] = blk[32*j +: 32];
    for (int j = 16; j < 64; j++)
      w[j] = w[j-16] + (rotr(w[j-15], 7) ^ rotr(w[j-15], 18) ^ (w[j-15] >> 3))
           + w[j-7] + (rotr(w[j-2], 17) ^ rotr(w[j-2], 19) ^ (w[j-2] >> 10));
    for (int j = 0; j < 8; j++) h[j] = st[32*j +: 32];
    a = h[0]; b = h[1]; c = h[2]; d = h[3]; e = h[4]; f = h[5]; g = h[6]; hh = h[7];
    for (int j = 0; j < 64; j++) begin
      t1 = hh + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[j] + w[j];
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    r[31:0] = h[0] + a;     r[63:32] = h[1] + b;   r[95:64] = h[2] + c;   r[127:96] = h[3] + d;
    r[159:128] = h[4] + e;  r[191:160] = h[5] + f; r[223:192] = h[6] + g; r[255:224] = h[7] + hh;
    return r;
  endfunction

  // Second 64-byte chunk of an 80-byte header, padded for a 640-bit message.
  function automatic logic [511:0] hdr_block(input logic [95:0] tail, input logic [31:0] n);
    logic [511:0] b;
    b = '0;
    for (int j = 0; j < 3; j++) b[32*j +: 32] = tail[32*j +: 32];
    b[32*3 +: 32]  = n;
    b[32*4 +: 32]  = 32'h80000000;
    b[32*15 +: 32] = 32'd640;
    return b;
  endfunction

  // A 32-byte digest padded as a 256-bit message.
  function automatic logic [511:0] dig_block(input logic [255:0] h1);
    logic [511:0] b;
    b = '0;
    for (int j = 0; j < 8; j++) b[32*j +: 32] = h1[32*j +: 32];
    b[32*8 +: 32]  = 32'h80000000;
    b[32*15 +: 32] = 32'd256;
    return b;
  endfunction

  function automatic logic [255:0] dsha(input logic [255:0] mid, input logic [95:0] tail,
                                        input logic [31:0] n);
    return compress(iv256(), dig_block(compress(mid, hdr_block(tail, n))));
  endfunction

  // Transform stand-in: result appears only RLAT cycles after the last ITER cycle.
  logic [255:0] xf_pend;
  int           xf_ctr;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      xf_ctr  <= 0;
      xf_pend <= '0;
    end else if (xf_feedback && xf_cnt == 6'(LOOP - 1)) begin
      xf_pend <= compress(xf_state, xf_input);
      xf_ctr  <= RLAT;
    end else if (xf_ctr > 0) begin
      xf_ctr <= xf_ctr - 1;
    end
  end
  assign xf_hash = (xf_ctr == 1) ? xf_pend : ~xf_pend;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after done.
  task automatic run_job(input logic [255:0] mid, input logic [95:0] tail,
                         input logic [31:0] s, input logic [31:0] e,
                         input logic [255:0] tgt, input int abort_at);
    int n, last, i, p;
    logic [31:0]  nonce;
    logic [255:0] h1, h2;
    logic         hit;
    n = int'(e - s) + 1;
    last = (abort_at > 0) ? abort_at : n * PER;
    hit = 1'b0; h1 = '0; h2 = '0;
    chk("job_ready_idle", job_ready, 1'b1);
    job_valid = 1'b1; job_midstate = mid; job_tail = tail;
    job_nonce_start = s; job_nonce_end = e; job_target = tgt;
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      if (c == 1) job_valid = 1'b0;
      if (c == 5) begin job_valid = 1'b1; job_nonce_start = ~s; end
      if (c == 7) job_valid = 1'b0;
      i = (c - 1) / PER;
      p = (c - 1) % PER + 1;
      nonce = s + 32'(i);
      if (p == 1) begin
        h1 = compress(mid, hdr_block(tail, nonce));
        h2 = compress(iv256(), dig_block(h1));
        hit = (h2 <= tgt);
      end
      chk("busy", busy, 1'b1);
      chk("cur_nonce", cur_nonce, nonce);
      chk("found", found, p == PER && hit);
      chk("done", done, p == PER && i == n - 1);
      if (p == 1) begin
        chk("p1_state", xf_state, mid);
        chk("p1_input", xf_input, hdr_block(tail, nonce));
        chk("p1_load_ctl", {xf_feedback, xf_cnt}, 7'd0);
      end
      if (p >= 2 && p <= LOOP) chk("iter_ctl", {xf_feedback, xf_cnt}, {1'b1, 6'(p - 1)});
      if (p == LOOP + 1) chk("wait_fb", xf_feedback, 1'b0);
      if (p == LOOP + RLAT + 1) begin
        chk("p2_state", xf_state, iv256());
        chk("p2_input", xf_input, dig_block(h1));
      end
      if (p == PER && hit) begin
        chk("found_nonce", found_nonce, nonce);
        chk("found_hash", found_hash, h2);
      end
      if (c == abort_at) abort = 1'b1;
    end
    @(negedge clk);
    abort = 1'b0;
    chk("post_done", done, abort_at > 0);
    chk("post_found", found, 1'b0);
    chk("post_busy", busy, 1'b0);
    chk("post_ready", job_ready, 1'b1);
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int j = 0; j < 8; j++) r[32*j +: 32] = $urandom;
    return r;
  endfunction

  logic [511:0] gblk;
  logic [255:0] gmid, tgt1, rmid, rtgt;
  logic [95:0]  gtail, rtail;
  logic [31:0]  rs;

  initial begin
    rst = 1'b1; job_valid = 1'b0; abort = 1'b0;
    job_midstate = '0; job_tail = '0; job_nonce_start = '0; job_nonce_end = '0; job_target = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", job_ready, 1'b0);
    chk("rst_outs", {busy, found, done, xf_feedback, xf_cnt, cur_nonce, found_nonce}, '0);
    chk("rst_hash", {found_hash, xf_state}, '0);
    rst = 1'b0;
    #1 chk("ready_after_rst", job_ready, 1'b1);

    // Genesis header: first chunk gives the midstate; merkle tail, time, bits form the tail.
    gblk = '0;
    gblk[32*0 +: 32]  = 32'h01000000;
    gblk[32*9 +: 32]  = 32'h3ba3edfd; gblk[32*10 +: 32] = 32'h7a7b12b2;
    gblk[32*11 +: 32] = 32'h7ac72c3e; gblk[32*12 +: 32] = 32'h67768f61;
    gblk[32*13 +: 32] = 32'h7fc81bc3; gblk[32*14 +: 32] = 32'h888a5132;
    gblk[32*15 +: 32] = 32'h3a9fb8aa;
    gmid  = compress(iv256(), gblk);
    gtail = {32'hffff001d, 32'h29ab5f49, 32'h4b1e5e4a};
    tgt1  = dsha(gmid, gtail, 32'h7C2BAC1D);

    // Single nonce, hash exactly equal to target: found and done together.
    run_job(gmid, gtail, 32'h7C2BAC1D, 32'h7C2BAC1D, tgt1, 0);
    run_job(gmid, gtail, 32'h7C2BAC1A, 32'h7C2BAC1F, tgt1, 0);

    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("idle_abort_done", done, 1'b0);
    chk("idle_abort_ready", job_ready, 1'b1);

    rmid = rnd256(); rtail = rnd256()[95:0];
    run_job(rmid, rtail, 32'd0, 32'd2, {256{1'b1}}, 0);
    chk("found_nonce_held", found_nonce, 32'd2);
    chk("found_hash_held", found_hash, dsha(rmid, rtail, 32'd2));

    run_job(rnd256(), rnd256()[95:0], 32'hFFFFFFFE, 32'h00000001, '0, 0);

    // Abort on the 10th P2_WAIT cycle of the second nonce, then a new job at once.
    rs = $urandom;
    run_job(rnd256(), rnd256()[95:0], rs, rs + 32'd4, {256{1'b1}}, PER + 2 * LOOP + RLAT + 10);
    for (int k = 0; k < 3; k++) begin
      rs = $urandom; rtgt = rnd256(); rtgt[255] = 1'b0;
      run_job(rnd256(), rnd256()[95:0], rs, rs + 32'd1, rtgt, 0);
    end

    // Reset during P1_ITER.
    job_valid = 1'b1; job_midstate = rnd256(); job_tail = rnd256()[95:0];
    job_nonce_start = 32'd9; job_nonce_end = 32'd20; job_target = {256{1'b1}};
    @(negedge clk);
    job_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_rst_fb", xf_feedback, 1'b1);
    rst = 1'b1;
    #1;
    chk("arst_outs", {job_ready, busy, found, done, xf_feedback, xf_cnt, cur_nonce, found_nonce}, '0);
    chk("arst_state", xf_state, '0);
    chk("arst_input", xf_input, '0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel_ready", job_ready, 1'b1);
    chk("rel_busy", busy, 1'b0);
    @(negedge clk);
    chk("rel_done", done, 1'b0);
    chk("rel_idle", job_ready, 1'b1);
    rs = $urandom;
    run_job(rnd256(), rnd256()[95:0], rs, rs, {256{1'b1}}, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
